// File: rtl/attopu_pkg.sv
// Shared attopu definitions: fetch FSM states, nextPCSel encodings and the word width.
// ST_FAULT exists only when FETCH_BUSERR_EN is defined.
package attopu_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] NPC_INC = 2'b00;
    localparam logic [1:0] NPC_REL = 2'b01;
    localparam logic [1:0] NPC_REG = 2'b10;  // any code with bit 1 set selects regPC

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
`ifdef FETCH_BUSERR_EN
        ,ST_FAULT = 2'd3
`endif
    } fetchState_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: increment, relative branch or register target.
// All arithmetic wraps modulo 2^16.
module pc_next
    import attopu_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [1:0]        nextPCSel,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] regPC,
    output logic [WORD_W-1:0] nextPc
);

    always_comb begin
        nextPc = pc + WORD_W'(1);
        if (nextPCSel[1])
            nextPc = regPC;
        else if (nextPCSel == NPC_REL)
            nextPc = pc + addr;
    end

endmodule

// File: rtl/fetch_unit.sv
// attopu instruction fetch: PC register, IDLE/FETCH/EXEC(/FAULT) FSM and instruction register.
// Define FETCH_BUSERR_EN to enable the FETCH timeout counter and the sticky FAULT state.
module fetch_unit
    import attopu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC      = 16'h0000,
    parameter int                FETCH_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        nextPCSel,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] regPC,
    input  logic              hold,
    output logic [WORD_W-1:0] iAddr,
    output logic              iReq,
    input  logic [WORD_W-1:0] iRdata,
    input  logic              iValid,
    output logic [WORD_W-1:0] instruction,
    output logic              instrValid,
    output logic [WORD_W-1:0] pc,
    output logic              fault
);

    if (FETCH_TIMEOUT < 1) begin : gBadTimeout
        $error("fetch_unit: FETCH_TIMEOUT must be at least 1");
    end

    fetchState_t       state, stateNext;
    logic [WORD_W-1:0] nextPc;

    pc_next uPcNext (
        .pc        (pc),
        .nextPCSel (nextPCSel),
        .addr      (addr),
        .regPC     (regPC),
        .nextPc    (nextPc)
    );

`ifdef FETCH_BUSERR_EN
    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    logic [CNT_W-1:0] waitCnt;
    logic             timeoutHit;

    // Fires on the FETCH_TIMEOUT-th consecutive cycle without iValid.
    assign timeoutHit = (waitCnt == CNT_W'(FETCH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            waitCnt <= '0;
        else if (state != ST_FETCH)
            waitCnt <= '0;
        else if (!iValid)
            waitCnt <= waitCnt + CNT_W'(1);
    end

    assign fault = (state == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  stateNext = ST_FETCH;
            ST_FETCH: begin
                // iValid wins over a timeout landing in the same cycle.
                if (iValid)
                    stateNext = ST_EXEC;
`ifdef FETCH_BUSERR_EN
                else if (timeoutHit)
                    stateNext = ST_FAULT;
`endif
            end
            ST_EXEC:  if (!hold) stateNext = ST_FETCH;
`ifdef FETCH_BUSERR_EN
            ST_FAULT: stateNext = ST_FAULT;
`endif
            default:  stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= '0;
        end else begin
            if (state == ST_FETCH && iValid)
                instruction <= iRdata;
            if (state == ST_EXEC && !hold)
                pc <= nextPc;
        end
    end

    assign iReq       = (state == ST_FETCH);
    assign iAddr      = pc;
    assign instrValid = (state == ST_EXEC);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, table-driven branch vectors, wait states, stall, reset mid-fetch.
// The timeout sequence is compiled when FETCH_BUSERR_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  nextPCSel;
    logic [15:0] addr, regPC, iRdata, iAddr, instruction, pc;
    logic        hold, iValid, iReq, instrValid, fault;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(16'h0000), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .nextPCSel(nextPCSel), .addr(addr), .regPC(regPC),
        .hold(hold), .iAddr(iAddr), .iReq(iReq), .iRdata(iRdata), .iValid(iValid),
        .instruction(instruction), .instrValid(instrValid), .pc(pc), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [15:0] regPC;
        logic [15:0] expPc;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t vecs[8];
        // pc starts at 1 after the first instruction
        vecs[0] = '{16'h1111, 2'b10, 16'h7777, 16'h0010, 16'h0010};
        vecs[1] = '{16'h2222, 2'b01, 16'hFFFC, 16'h5555, 16'h000C};
        vecs[2] = '{16'h3333, 2'b00, 16'h7777, 16'h5555, 16'h000D};
        vecs[3] = '{16'h4444, 2'b11, 16'h0003, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{16'h5555, 2'b00, 16'h0100, 16'h1234, 16'h0000};
        vecs[5] = '{16'h6666, 2'b01, 16'h0005, 16'h9999, 16'h0005};
        vecs[6] = '{16'h7777, 2'b01, 16'h8000, 16'h0001, 16'h8005};
        vecs[7] = '{16'h8888, 2'b10, 16'h0002, 16'h1234, 16'h1234};

        rst = 1'b1; nextPCSel = 2'b00; addr = '0; regPC = '0;
        hold = 1'b0; iValid = 1'b0; iRdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_iReq", 16'(iReq), 16'h0);
        chk("rst_instrValid", 16'(instrValid), 16'h0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instruction", instruction, 16'h0000);
        chk("rst_fault", 16'(fault), 16'h0);

        // First fetch: one IDLE cycle, then FETCH at address 0
        rst = 1'b0;
        chk("idle_iReq", 16'(iReq), 16'h0);
        tick();
        chk("fetch0_iReq", 16'(iReq), 16'h1);
        chk("fetch0_iAddr", iAddr, 16'h0000);
        iValid = 1'b1; iRdata = 16'h2005;
        tick();
        chk("exec0_instruction", instruction, 16'h2005);
        chk("exec0_instrValid", 16'(instrValid), 16'h1);
        chk("exec0_iReq", 16'(iReq), 16'h0);
        iValid = 1'b0; nextPCSel = 2'b00;
        tick();
        chk("fetch1_pc", pc, 16'h0001);
        chk("fetch1_iReq", 16'(iReq), 16'h1);

        // Branch vectors, zero-wait memory
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_iAddr", i), iAddr, pc);
            iValid = 1'b1; iRdata = vecs[i].data;
            tick();
            chk($sformatf("v%0d_instr", i), instruction, vecs[i].data);
            chk($sformatf("v%0d_instrValid", i), 16'(instrValid), 16'h1);
            iValid = 1'b0;
            nextPCSel = vecs[i].sel; addr = vecs[i].addr; regPC = vecs[i].regPC;
            tick();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].expPc);
            chk($sformatf("v%0d_iReq", i), 16'(iReq), 16'h1);
            nextPCSel = 2'b11; addr = 16'hDEAD; regPC = 16'hBEEF;
        end

        // Wait states: request held stable for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wait%0d_iReq", i), 16'(iReq), 16'h1);
            chk($sformatf("wait%0d_iAddr", i), iAddr, 16'h1234);
            chk($sformatf("wait%0d_instrValid", i), 16'(instrValid), 16'h0);
        end
        iValid = 1'b1; iRdata = 16'hABCD; hold = 1'b1;
        tick();
        chk("wait_capture", instruction, 16'hABCD);

        // Stall 4 EXEC cycles; stray iValid during EXEC is ignored
        iRdata = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold%0d_instrValid", i), 16'(instrValid), 16'h1);
            chk($sformatf("hold%0d_iReq", i), 16'(iReq), 16'h0);
            chk($sformatf("hold%0d_pc", i), pc, 16'h1234);
            chk($sformatf("hold%0d_instr", i), instruction, 16'hABCD);
            if (i == 3) begin
                hold = 1'b0; iValid = 1'b0; nextPCSel = 2'b00;
            end
            tick();
        end
        chk("release_pc", pc, 16'h1235);
        chk("release_iReq", 16'(iReq), 16'h1);
        chk("release_instr", instruction, 16'hABCD);

`ifndef FETCH_BUSERR_EN
        // Without the timeout feature FETCH waits indefinitely
        for (int i = 0; i < 20; i++) tick();
        chk("nofault_fault", 16'(fault), 16'h0);
        chk("nofault_iReq", 16'(iReq), 16'h1);
`endif

        // Reset mid-FETCH, late iValid during IDLE is ignored
        rst = 1'b1;
        tick();
        chk("rstmid_iReq", 16'(iReq), 16'h0);
        chk("rstmid_pc", pc, 16'h0000);
        rst = 1'b0; iValid = 1'b1; iRdata = 16'hBEEF;
        tick();
        chk("rstmid_instr", instruction, 16'h0000);
        chk("rstmid_instrValid", 16'(instrValid), 16'h0);
        chk("rstmid_refetch", 16'(iReq), 16'h1);
        chk("rstmid_iAddr", iAddr, 16'h0000);
        iValid = 1'b0;

`ifdef FETCH_BUSERR_EN
        // Now in FETCH cycle 1 with no iValid; FAULT after cycle 4
        tick(); tick(); tick();
        chk("to_prefault", 16'(fault), 16'h0);
        chk("to_prefault_iReq", 16'(iReq), 16'h1);
        tick();
        chk("to_fault", 16'(fault), 16'h1);
        chk("to_fault_iReq", 16'(iReq), 16'h0);
        iValid = 1'b1; iRdata = 16'h7E57;
        tick(); tick(); tick();
        chk("to_sticky", 16'(fault), 16'h1);
        chk("to_sticky_instrValid", 16'(instrValid), 16'h0);
        chk("to_frozen_pc", pc, 16'h0000);
        chk("to_frozen_instr", instruction, 16'h0000);
        iValid = 1'b0; rst = 1'b1;
        tick();
        chk("to_rst_fault", 16'(fault), 16'h0);
        rst = 1'b0;
        tick();
        // iValid on the 4th FETCH cycle beats the timeout
        tick(); tick(); tick();
        iValid = 1'b1; iRdata = 16'h4321;
        tick();
        chk("to_late_fault", 16'(fault), 16'h0);
        chk("to_late_instr", instruction, 16'h4321);
        chk("to_late_instrValid", 16'(instrValid), 16'h1);
        iValid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
